mux4_rr_collector: RTL and testbench

- Four-channel to one-channel collector: merges four valid/ready input streams onto one output stream.
- Tags each output word with its source channel index on out_sel, so a downstream 1-to-4 demux can route it back.
- Round-robin arbitration with one output register stage. Sits between four producers and the shared link.

---
 rtl/mux4_pkg.sv | 21 ++
 rtl/rr_arbiter4.sv | 33 +++
 rtl/mux4_rr_collector.sv | 88 ++++++++
 tb/tb_mux4_rr_collector.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// Shared channel constants and index type for the 4:1 collector and its matching 1:4 demux.
// Channel indices wrap modulo NUM_CH because the index type is exactly CH_W bits wide.
package mux4_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   typedef logic [CH_W-1:0] ch_idx_t;

   localparam ch_idx_t CH0       = 2'd0;
   localparam ch_idx_t CH1       = 2'd1;
   localparam ch_idx_t CH2       = 2'd2;
   localparam ch_idx_t CH3       = 2'd3;
   localparam ch_idx_t RESET_PTR = CH3;

   // Channel reached by stepping 'step' positions past 'base'; wraps through CH_W-bit arithmetic.
   function automatic ch_idx_t ch_after(input ch_idx_t base, input int unsigned step);
      return base + ch_idx_t'(step);
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin arbiter over four requests.
// Search order is last+1, last+2, last+3, last, so the most recent winner has lowest priority.
module rr_arbiter4
   import mux4_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  ch_idx_t           last,
   input  logic              en,
   output logic [NUM_CH-1:0] gnt,
   output ch_idx_t           gnt_idx,
   output logic              gnt_any
);

   ch_idx_t cand;
   logic    found;

   always_comb begin
      cand    = last;
      found   = 1'b0;
      gnt_idx = last;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = ch_after(last, k);
         if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      // A winner is still computed when disabled, but nothing is granted.
      gnt_any = found & en;
      gnt     = NUM_CH'(gnt_any) << gnt_idx;
   end

endmodule

// File: rtl/mux4_rr_collector.sv
// Four-to-one valid/ready collector with round-robin arbitration and one output register stage.
// Each output word carries its source channel index on out_sel.
module mux4_rr_collector
   import mux4_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in0,
   input  logic [WIDTH-1:0]  in1,
   input  logic [WIDTH-1:0]  in2,
   input  logic [WIDTH-1:0]  in3,
   input  logic [NUM_CH-1:0] valid_in,
   output logic [NUM_CH-1:0] ready_in,
   output logic [WIDTH-1:0]  out,
   output logic [CH_W-1:0]   out_sel,
   output logic              out_valid,
   input  logic              out_ready
);

   logic [WIDTH-1:0]  ch_data [NUM_CH];
   logic [NUM_CH-1:0] gnt;
   ch_idx_t           gnt_idx;
   logic              gnt_any;
   logic              load_en;

   logic [WIDTH-1:0]  out_q, out_d;
   ch_idx_t           out_sel_q, out_sel_d;
   logic              out_valid_q, out_valid_d;
   ch_idx_t           last_q, last_d;

   assign ch_data[0] = in0;
   assign ch_data[1] = in1;
   assign ch_data[2] = in2;
   assign ch_data[3] = in3;

   // The register can take a word when empty or when its current word drains this cycle.
   assign load_en = !out_valid_q | out_ready;

   rr_arbiter4 u_arb (
      .req     (valid_in),
      .last    (last_q),
      .en      (load_en & rst_n),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign ready_in[gi] = gnt[gi] & rst_n;
   end

   always_comb begin
      out_d       = out_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      last_d      = last_q;
      if (gnt_any) begin
         out_d       = ch_data[gnt_idx];
         out_sel_d   = gnt_idx;
         out_valid_d = 1'b1;
         last_d      = gnt_idx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_sel_q   <= CH0;
         out_valid_q <= 1'b0;
         last_q      <= RESET_PTR;
      end else begin
         out_q       <= out_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         last_q      <= last_d;
      end
   end

   assign out       = out_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux4_rr_collector.sv
// Self-checking bench: directed vector table for the listed scenarios, then random traffic
// compared against a round-robin reference model.
module tb_mux4_rr_collector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din [4];
   logic [3:0] valid_in;
   logic [3:0] ready_in;
   logic [7:0] out;
   logic [1:0] out_sel;
   logic       out_valid;
   logic       out_ready;

   int checks   = 0;
   int failures = 0;

   mux4_rr_collector #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0       (din[0]),
      .in1       (din[1]),
      .in2       (din[2]),
      .in3       (din[3]),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .out       (out),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            rst_n;
      logic [3:0]      valid;
      logic            ordy;
      logic [3:0][7:0] d;
      logic [3:0]      exp_rdy;
      logic            exp_ov;
      logic [1:0]      exp_sel;
      logic [7:0]      exp_out;
      logic            chk_data;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: pointer as a plain integer, output register as plain values.
   int         m_last = 3;
   logic       m_ov   = 1'b0;
   logic [1:0] m_sel  = 2'd0;
   logic [7:0] m_out  = 8'd0;

   function automatic int model_pick();
      if (!rst_n) return -1;
      if (m_ov && !out_ready) return -1;
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (m_last + k) % 4;
         if (valid_in[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_edge(input int pick);
      if (!rst_n) begin
         m_last = 3; m_ov = 1'b0; m_sel = 2'd0; m_out = 8'd0;
      end else if (pick >= 0) begin
         m_last = pick; m_ov = 1'b1; m_sel = 2'(pick); m_out = din[pick];
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] v, input logic o, input logic [3:0][7:0] d);
      rst_n = r; valid_in = v; out_ready = o;
      for (int k = 0; k < 4; k++) din[k] = d[k];
      #1;
   endtask

   task automatic add(input logic r, input logic [3:0] v, input logic o, input logic [3:0][7:0] d,
                      input logic [3:0] er, input logic eov, input logic [1:0] esel,
                      input logic [7:0] eout, input logic cd);
      vec_t t;
      t.rst_n = r; t.valid = v; t.ordy = o; t.d = d;
      t.exp_rdy = er; t.exp_ov = eov; t.exp_sel = esel; t.exp_out = eout; t.chk_data = cd;
      vecs.push_back(t);
   endtask

   initial begin
      logic [3:0][7:0] drot, dsingle, dbp, drnd;
      int pick;

      drot    = {8'h43, 8'h32, 8'h21, 8'h10};
      dsingle = {8'h43, 8'hA5, 8'h21, 8'h10};
      dbp     = {8'h43, 8'h32, 8'h5A, 8'h10};

      // Reset held two cycles with every channel requesting.
      add(0, 4'b1111, 1, drot, 4'b0000, 0, 2'd0, 8'h00, 1);
      add(0, 4'b1111, 1, drot, 4'b0000, 0, 2'd0, 8'h00, 1);
      // Single channel 2, then drain with nothing new.
      add(1, 4'b0100, 1, dsingle, 4'b0100, 1, 2'd2, 8'hA5, 1);
      add(1, 4'b0000, 1, dsingle, 4'b0000, 0, 2'd0, 8'h00, 0);
      // Return pointer to 3, then full rotation starting at channel 0.
      add(0, 4'b0000, 1, drot, 4'b0000, 0, 2'd0, 8'h00, 1);
      for (int i = 0; i < 8; i++)
         add(1, 4'b1111, 1, drot, 4'(1 << (i % 4)), 1, 2'(i % 4), drot[i % 4], 1);
      // Bring pointer to 0, then channels 3 and 0 alternate.
      add(1, 4'b0001, 1, drot, 4'b0001, 1, 2'd0, 8'h10, 1);
      for (int i = 0; i < 4; i++)
         add(1, 4'b1001, 1, drot, (i % 2 == 0) ? 4'b1000 : 4'b0001, 1,
             (i % 2 == 0) ? 2'd3 : 2'd0, (i % 2 == 0) ? 8'h43 : 8'h10, 1);
      // Backpressure: word from channel 1 held three cycles, then drain-and-load on channel 2.
      add(1, 4'b0010, 1, dbp, 4'b0010, 1, 2'd1, 8'h5A, 1);
      for (int i = 0; i < 3; i++)
         add(1, 4'b1111, 0, dbp, 4'b0000, 1, 2'd1, 8'h5A, 1);
      add(1, 4'b1111, 1, dbp, 4'b0100, 1, 2'd2, 8'h32, 1);
      // Mid-operation reset discards the word; next grant is channel 0.
      add(0, 4'b1111, 1, drot, 4'b0000, 0, 2'd0, 8'h00, 1);
      add(1, 4'b1111, 1, drot, 4'b0001, 1, 2'd0, 8'h10, 1);

      rst_n = 1'b0; valid_in = 4'b0; out_ready = 1'b0;
      for (int k = 0; k < 4; k++) din[k] = 8'h00;
      @(posedge clk); #1;
      m_last = 3; m_ov = 1'b0; m_sel = 2'd0; m_out = 8'd0;

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].valid, vecs[i].ordy, vecs[i].d);
         chk($sformatf("vec%0d ready_in", i), 32'(ready_in), 32'(vecs[i].exp_rdy));
         pick = model_pick();
         @(posedge clk);
         model_edge(pick);
         #1;
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         if (vecs[i].chk_data) begin
            chk($sformatf("vec%0d out_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
            chk($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].exp_out));
         end
         $display("vec %0d rst_n=%b valid=%b ordy=%b ready=%b -> ov=%b sel=%0d out=%h",
                  i, vecs[i].rst_n, vecs[i].valid, vecs[i].ordy, ready_in, out_valid, out_sel, out);
      end

      for (int i = 0; i < 600; i++) begin
         drnd = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
         drive($urandom_range(0, 39) != 0, 4'($urandom), $urandom_range(0, 3) != 0, drnd);
         pick = model_pick();
         chk("rand ready_in", 32'(ready_in), (pick >= 0) ? 32'(1 << pick) : 32'd0);
         @(posedge clk);
         model_edge(pick);
         #1;
         chk("rand out_valid", 32'(out_valid), 32'(m_ov));
         if (m_ov || !rst_n) begin
            chk("rand out_sel", 32'(out_sel), 32'(m_sel));
            chk("rand out", 32'(out), 32'(m_out));
         end
         if (pick >= 0)
            $display("rand %0d grant ch%0d data=%h", i, pick, m_out);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
